// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback source select, halt/dump sequencing
// and a saturating retire counter.
module mem_wb_stage #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          flush,
  input  logic [DW-1:0] mem_out,
  input  logic [DW-1:0] ALU_out_out,
  input  logic [DW-1:0] pc_inc,
  input  logic [1:0]    wb_sel,
  input  logic          reg_write,
  input  logic [RW-1:0] dest_reg,
  input  logic          halt_in,
  output logic [DW-1:0] wb_data,
  output logic [RW-1:0] wb_reg,
  output logic          wb_en,
  output logic          wb_valid,
  output logic          createdump,
  output logic          halted,
  output logic          sel_err,
  output logic [15:0]   retire_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DUMP   = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t        state, state_next;
  logic          load;
  logic          sel_legal;
  logic [DW-1:0] sel_data;

  // Only a live, unflushed instruction in RUN enters the register; all else is a bubble.
  assign load = in_valid & ~flush & (state == RUN);

  always_comb begin
    sel_data  = '0;
    sel_legal = 1'b1;
    case (wb_sel)
      2'b00:   sel_data = ALU_out_out;
      2'b01:   sel_data = mem_out;
      2'b10:   sel_data = pc_inc;
      default: sel_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (load && halt_in) state_next = DUMP;
      DUMP:    state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_data    <= '0;
      wb_reg     <= '0;
      wb_en      <= 1'b0;
      wb_valid   <= 1'b0;
      sel_err    <= 1'b0;
      retire_cnt <= '0;
    end else if (load) begin
      wb_data  <= sel_data;
      wb_reg   <= dest_reg;
      wb_en    <= reg_write & ~halt_in & sel_legal;
      wb_valid <= 1'b1;
      if (!sel_legal) begin
        sel_err <= 1'b1;
      end
      // Counter holds at all-ones rather than wrapping.
      if (retire_cnt != 16'hFFFF) begin
        retire_cnt <= retire_cnt + 16'd1;
      end
    end else begin
      wb_data  <= '0;
      wb_reg   <= '0;
      wb_en    <= 1'b0;
      wb_valid <= 1'b0;
    end
  end

  assign createdump = (state == DUMP);
  assign halted     = (state == HALTED);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: datapath selects, bubbles, halt/dump,
// reset during dump, illegal select and counter saturation.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        flush;
  logic [15:0] mem_out;
  logic [15:0] ALU_out_out;
  logic [15:0] pc_inc;
  logic [1:0]  wb_sel;
  logic        reg_write;
  logic [2:0]  dest_reg;
  logic        halt_in;
  logic [15:0] wb_data;
  logic [2:0]  wb_reg;
  logic        wb_en;
  logic        wb_valid;
  logic        createdump;
  logic        halted;
  logic        sel_err;
  logic [15:0] retire_cnt;

  int vectors;
  int miscompares;

  mem_wb_stage #(.DW(16), .RW(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .flush       (flush),
    .mem_out     (mem_out),
    .ALU_out_out (ALU_out_out),
    .pc_inc      (pc_inc),
    .wb_sel      (wb_sel),
    .reg_write   (reg_write),
    .dest_reg    (dest_reg),
    .halt_in     (halt_in),
    .wb_data     (wb_data),
    .wb_reg      (wb_reg),
    .wb_en       (wb_en),
    .wb_valid    (wb_valid),
    .createdump  (createdump),
    .halted      (halted),
    .sel_err     (sel_err),
    .retire_cnt  (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction, then sample just after the capturing edge.
  task automatic apply_stimulus(input logic v, input logic f, input logic [1:0] sel,
                                input logic [15:0] alu, input logic [15:0] mem,
                                input logic [15:0] pc, input logic rw,
                                input logic [2:0] dst, input logic hlt);
    in_valid    = v;
    flush       = f;
    wb_sel      = sel;
    ALU_out_out = alu;
    mem_out     = mem;
    pc_inc      = pc;
    reg_write   = rw;
    dest_reg    = dst;
    halt_in     = hlt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_data"}, 32'(wb_data), 32'h0);
    check_output({tag, "_en"}, 32'(wb_en), 32'h0);
    check_output({tag, "_valid"}, 32'(wb_valid), 32'h0);
    check_output({tag, "_dump"}, 32'(createdump), 32'h0);
    check_output({tag, "_halted"}, 32'(halted), 32'h0);
    check_output({tag, "_selerr"}, 32'(sel_err), 32'h0);
    check_output({tag, "_cnt"}, 32'(retire_cnt), 32'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    in_valid    = 1'b0;
    flush       = 1'b0;
    mem_out     = '0;
    ALU_out_out = '0;
    pc_inc      = '0;
    wb_sel      = 2'b00;
    reg_write   = 1'b0;
    dest_reg    = '0;
    halt_in     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // ALU path
    apply_stimulus(1, 0, 2'b00, 16'h1234, 16'h0, 16'h0, 1, 3'd5, 0);
    check_output("alu_data", 32'(wb_data), 32'h1234);
    check_output("alu_reg", 32'(wb_reg), 32'd5);
    check_output("alu_en", 32'(wb_en), 32'h1);
    check_output("alu_valid", 32'(wb_valid), 32'h1);
    check_output("alu_cnt", 32'(retire_cnt), 32'd1);

    // Memory then link, back to back
    apply_stimulus(1, 0, 2'b01, 16'h0000, 16'hBEEF, 16'h0, 1, 3'd2, 0);
    check_output("mem_data", 32'(wb_data), 32'hBEEF);
    check_output("mem_reg", 32'(wb_reg), 32'd2);
    apply_stimulus(1, 0, 2'b10, 16'h0000, 16'h0, 16'h0042, 1, 3'd7, 0);
    check_output("link_data", 32'(wb_data), 32'h0042);
    check_output("link_cnt", 32'(retire_cnt), 32'd3);

    // Flush beats in_valid, then an idle cycle
    apply_stimulus(1, 1, 2'b00, 16'h7777, 16'h0, 16'h0, 1, 3'd4, 0);
    check_output("flush_en", 32'(wb_en), 32'h0);
    check_output("flush_valid", 32'(wb_valid), 32'h0);
    check_output("flush_data", 32'(wb_data), 32'h0);
    check_output("flush_reg", 32'(wb_reg), 32'h0);
    check_output("flush_cnt", 32'(retire_cnt), 32'd3);
    apply_stimulus(0, 0, 2'b00, 16'h6666, 16'h0, 16'h0, 1, 3'd4, 0);
    check_output("idle_en", 32'(wb_en), 32'h0);
    check_output("idle_cnt", 32'(retire_cnt), 32'd3);

    // Illegal select retires but does not write; flag is sticky
    apply_stimulus(1, 0, 2'b11, 16'h5555, 16'h5555, 16'h5555, 1, 3'd6, 0);
    check_output("ill_en", 32'(wb_en), 32'h0);
    check_output("ill_data", 32'(wb_data), 32'h0);
    check_output("ill_valid", 32'(wb_valid), 32'h1);
    check_output("ill_selerr", 32'(sel_err), 32'h1);
    check_output("ill_cnt", 32'(retire_cnt), 32'd4);
    apply_stimulus(1, 0, 2'b00, 16'h00AA, 16'h0, 16'h0, 1, 3'd1, 0);
    check_output("post_ill_en", 32'(wb_en), 32'h1);
    check_output("post_ill_selerr", 32'(sel_err), 32'h1);

    // Flushed HALT is killed
    apply_stimulus(1, 1, 2'b00, 16'h0, 16'h0, 16'h0, 1, 3'd3, 1);
    check_output("fh_dump", 32'(createdump), 32'h0);
    check_output("fh_valid", 32'(wb_valid), 32'h0);
    check_output("fh_cnt", 32'(retire_cnt), 32'd5);

    // HALT, followed by an ADD that must be dropped
    apply_stimulus(1, 0, 2'b00, 16'h9999, 16'h0, 16'h0, 1, 3'd3, 1);
    check_output("halt_dump", 32'(createdump), 32'h1);
    check_output("halt_valid", 32'(wb_valid), 32'h1);
    check_output("halt_en", 32'(wb_en), 32'h0);
    check_output("halt_halted", 32'(halted), 32'h0);
    check_output("halt_cnt", 32'(retire_cnt), 32'd6);
    apply_stimulus(1, 0, 2'b00, 16'h0123, 16'h0, 16'h0, 1, 3'd2, 0);
    check_output("add_dump", 32'(createdump), 32'h0);
    check_output("add_halted", 32'(halted), 32'h1);
    check_output("add_en", 32'(wb_en), 32'h0);
    check_output("add_valid", 32'(wb_valid), 32'h0);
    check_output("add_cnt", 32'(retire_cnt), 32'd6);
    apply_stimulus(1, 0, 2'b00, 16'h0124, 16'h0, 16'h0, 1, 3'd2, 0);
    check_output("stay_halted", 32'(halted), 32'h1);

    // Reset out of HALTED, then one ALU op
    #2 rst = 1'b0;
    #1 check_all_zero("rst_halted");
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1, 0, 2'b00, 16'h0BAD, 16'h0, 16'h0, 1, 3'd1, 0);
    check_output("rerun_data", 32'(wb_data), 32'h0BAD);
    check_output("rerun_cnt", 32'(retire_cnt), 32'd1);

    // Reset asserted while in DUMP
    apply_stimulus(1, 0, 2'b00, 16'h0, 16'h0, 16'h0, 1, 3'd0, 1);
    check_output("dump2", 32'(createdump), 32'h1);
    #2 rst = 1'b0;
    #1 check_all_zero("rst_dump");
    rst = 1'b1;
    apply_stimulus(1, 0, 2'b00, 16'h4321, 16'h0, 16'h0, 1, 3'd2, 0);
    check_output("after_abort_data", 32'(wb_data), 32'h4321);
    check_output("after_abort_en", 32'(wb_en), 32'h1);
    check_output("after_abort_dump", 32'(createdump), 32'h0);
    check_output("after_abort_cnt", 32'(retire_cnt), 32'd1);

    // Saturation: 65533 more loads reach 0xFFFE, then pin at 0xFFFF
    in_valid = 1'b1;
    for (int i = 0; i < 65533; i++) @(posedge clk);
    #1;
    check_output("sat_fffe", 32'(retire_cnt), 32'hFFFE);
    apply_stimulus(1, 0, 2'b00, 16'h1, 16'h0, 16'h0, 1, 3'd1, 0);
    check_output("sat_ffff", 32'(retire_cnt), 32'hFFFF);
    apply_stimulus(1, 0, 2'b00, 16'h2, 16'h0, 16'h0, 1, 3'd1, 0);
    apply_stimulus(1, 0, 2'b00, 16'h3, 16'h0, 16'h0, 1, 3'd1, 0);
    check_output("sat_hold", 32'(retire_cnt), 32'hFFFF);
    check_output("sat_data", 32'(wb_data), 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
